// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, prefix byte values and
// the odd-parity rule. The key controller downstream uses the same constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

    // True when the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ((^data) ^ parity) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchroniser for one raw PS/2 line, with an optional glitch filter and a
// single-cycle falling-edge pulse on the filtered level. With FILTER=0 the
// level simply follows the last synchroniser stage.
module ps2_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_FILTER = 4,
    parameter bit FILTER        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(GLITCH_FILTER + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // A new level is adopted only after it has persisted for GLITCH_FILTER consecutive cycles.
    always_comb begin
        sync_d  = (sync_q << 1) | SYNC_STAGES'(din);
        cnt_d   = '0;
        level_d = level_q;
        if (!FILTER) begin
            level_d = synced;
        end else if (synced != level_q) begin
            if (cnt_q == CW'(GLITCH_FILTER - 1)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_d = level_q & ~level_d;
    end

    // Lines idle high, so the synchroniser and filtered level come out of reset at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: deserialises 11-bit frames clocked by the
// filtered keyboard clock, checks start/parity/stop, folds F0/E0 prefixes into
// flags and emits one scan code per key event. Everything runs on clock27.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int GLITCH_FILTER  = 4,
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       keyboardClock,
    input  logic       keyboardData,
    output logic [7:0] scanCode,
    output logic       codeValid,
    output logic       isBreak,
    output logic       isExtended,
    output logic       frameError
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic kbd_clk_fall;
    logic kbd_clk_level_unused;
    logic kbd_data;
    logic kbd_data_fall_unused;

    ps2_input_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .GLITCH_FILTER(GLITCH_FILTER),
        .FILTER       (1'b1)
    ) u_clk_filter (
        .clk  (clock27),
        .rst  (reset),
        .din  (keyboardClock),
        .level(kbd_clk_level_unused),
        .fall (kbd_clk_fall)
    );

    ps2_input_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .GLITCH_FILTER(GLITCH_FILTER),
        .FILTER       (1'b0)
    ) u_data_sync (
        .clk  (clock27),
        .rst  (reset),
        .din  (keyboardData),
        .level(kbd_data),
        .fall (kbd_data_fall_unused)
    );

    ps2_state_t      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            parity_q, parity_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            pend_break_q, pend_break_d;
    logic            pend_ext_q, pend_ext_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            code_valid_q, code_valid_d;
    logic            is_break_q, is_break_d;
    logic            is_ext_q, is_ext_d;
    logic            frame_error_q, frame_error_d;
    logic            frame_ok;
    logic            timeout;

    // Next-state logic: a keyboard clock fall always takes priority over the watchdog expiring.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        parity_d      = parity_q;
        wd_d          = wd_q;
        pend_break_d  = pend_break_q;
        pend_ext_d    = pend_ext_q;
        scan_code_d   = scan_code_q;
        is_break_d    = is_break_q;
        is_ext_d      = is_ext_q;
        code_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        frame_ok = kbd_data && odd_parity_ok(shreg_q, parity_q);
        timeout  = (state_q != ST_IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES));

        if (state_q == ST_IDLE || kbd_clk_fall) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
            wd_d = wd_q + WD_W'(1);
        end

        if (kbd_clk_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!kbd_data) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {kbd_data, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = kbd_data;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!frame_ok) begin
                        frame_error_d = 1'b1;
                        pend_break_d  = 1'b0;
                        pend_ext_d    = 1'b0;
                    end else if (shreg_q == PS2_BREAK_PREFIX) begin
                        pend_break_d = 1'b1;
                    end else if (shreg_q == PS2_EXT_PREFIX) begin
                        pend_ext_d = 1'b1;
                    end else begin
                        scan_code_d  = shreg_q;
                        is_break_d   = pend_break_q;
                        is_ext_d     = pend_ext_q;
                        code_valid_d = 1'b1;
                        pend_break_d = 1'b0;
                        pend_ext_d   = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            frame_error_d = 1'b1;
            pend_break_d  = 1'b0;
            pend_ext_d    = 1'b0;
            state_d       = ST_IDLE;
        end
    end

    // Single register bank for the FSM, datapath and registered outputs.
    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            parity_q      <= 1'b0;
            wd_q          <= '0;
            pend_break_q  <= 1'b0;
            pend_ext_q    <= 1'b0;
            scan_code_q   <= 8'h00;
            code_valid_q  <= 1'b0;
            is_break_q    <= 1'b0;
            is_ext_q      <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            parity_q      <= parity_d;
            wd_q          <= wd_d;
            pend_break_q  <= pend_break_d;
            pend_ext_q    <= pend_ext_d;
            scan_code_q   <= scan_code_d;
            code_valid_q  <= code_valid_d;
            is_break_q    <= is_break_d;
            is_ext_q      <= is_ext_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign scanCode   = scan_code_q;
    assign codeValid  = code_valid_q;
    assign isBreak    = is_break_q;
    assign isExtended = is_ext_q;
    assign frameError = frame_error_q;

endmodule
